button_conditioner: RTL and testbench

//   Input-conditioning stage upstream of the adder top level. Synchronises the

---
 rtl/button_conditioner.sv | 92 +++++++++
 tb/tb_button_conditioner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Purpose : synchronise active-low push-buttons and slider switches into Clk,
//           debounce each button, emit clean level plus 1-cycle press/release pulses.
// Latency : switches 2 edges; a button change held from edge k is seen at edge k+D+1.
// Backpressure: none; free-running conditioning stage, every output is registered.
//
// Ports:
//   Clk, Reset      clock and synchronous active-high reset
//   btn_n_i         raw push-buttons, active low
//   sw_i            raw slider switches
//   btn_level_o     debounced pressed level (active high)
//   btn_press_o     1-cycle pulse when a press is accepted
//   btn_release_o   1-cycle pulse when a release is accepted
//   sw_o            synchronised switches
module button_conditioner #(
  parameter int N_BTN           = 2,
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N_BTN-1:0]    btn_n_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic [N_BTN-1:0]    btn_level_o,
  output logic [N_BTN-1:0]    btn_press_o,
  output logic [N_BTN-1:0]    btn_release_o,
  output logic [SW_WIDTH-1:0] sw_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Button synchronisers hold the inverted (pressed = 1) sense.
  logic [N_BTN-1:0]           btn_sync1_q, btn_sync2_q;
  logic [N_BTN-1:0]           stable_q, stable_d;
  logic [N_BTN-1:0]           press_q, press_d;
  logic [N_BTN-1:0]           release_q, release_d;
  logic [N_BTN-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [SW_WIDTH-1:0]        sw_sync1_q, sw_q;

  // Debounce: a differing synchronised level must persist for D consecutive
  // edges (counting 0..D-1, then accepting on the D-th). Any agreement with the
  // stable level clears the count, so short bounces are absorbed. The counter
  // is bounded by the CNT_MAX compare and never wraps.
  always_comb begin
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (btn_sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i]  = btn_sync2_q[i];
        cnt_d[i]     = '0;
        // Edge pulses are registered alongside the stable update so they
        // line up with the level change.
        press_d[i]   = btn_sync2_q[i];
        release_d[i] = ~btn_sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      btn_sync1_q <= '0;
      btn_sync2_q <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      press_q     <= '0;
      release_q   <= '0;
      sw_sync1_q  <= '0;
      sw_q        <= '0;
    end else begin
      btn_sync1_q <= ~btn_n_i;
      btn_sync2_q <= btn_sync1_q;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
      sw_sync1_q  <= sw_i;
      sw_q        <= sw_sync1_q;
    end
  end

  assign btn_level_o   = stable_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;
  assign sw_o          = sw_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Each scenario task performs its own inline comparisons.
module tb_button_conditioner;

  localparam int N_BTN = 2;
  localparam int SW_W  = 16;
  localparam int D     = 4;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [N_BTN-1:0] btn_n_i;
  logic [SW_W-1:0]  sw_i;
  logic [N_BTN-1:0] btn_level_o, btn_press_o, btn_release_o;
  logic [SW_W-1:0]  sw_o;

  int n_checks = 0;
  int n_pass   = 0;

  button_conditioner #(
    .N_BTN(N_BTN), .SW_WIDTH(SW_W), .DEBOUNCE_CYCLES(D)
  ) dut (
    .Clk(Clk), .Reset(Reset), .btn_n_i(btn_n_i), .sw_i(sw_i),
    .btn_level_o(btn_level_o), .btn_press_o(btn_press_o),
    .btn_release_o(btn_release_o), .sw_o(sw_o)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; btn_n_i = 2'b11; sw_i = 16'h0000;
    tick(); tick();
    n_checks++; if (btn_level_o !== 2'b00) $display("FAIL reset_level got %b want 00", btn_level_o); else n_pass++;
    n_checks++; if (btn_press_o !== 2'b00) $display("FAIL reset_press got %b want 00", btn_press_o); else n_pass++;
    n_checks++; if (btn_release_o !== 2'b00) $display("FAIL reset_release got %b want 00", btn_release_o); else n_pass++;
    n_checks++; if (sw_o !== 16'h0000) $display("FAIL reset_sw got %h want 0000", sw_o); else n_pass++;
    Reset = 1'b0;
    sw_i = 16'h03A8;
    tick();
    n_checks++; if (sw_o !== 16'h0000) $display("FAIL sw_one_edge got %h want 0000", sw_o); else n_pass++;
    tick();
    n_checks++; if (sw_o !== 16'h03A8) $display("FAIL sw_two_edges got %h want 03a8", sw_o); else n_pass++;
    sw_i = 16'hC35A;
    tick(); tick();
    n_checks++; if (sw_o !== 16'hC35A) $display("FAIL sw_second got %h want c35a", sw_o); else n_pass++;
    n_checks++; if (btn_level_o !== 2'b00) $display("FAIL idle_level got %b want 00", btn_level_o); else n_pass++;
  endtask

  task automatic test_press_latency();
    btn_n_i = 2'b10;              // press button 0 before edge k
    for (int i = 0; i < D + 1; i++) begin   // edges k .. k+4
      tick();
      n_checks++; if (btn_level_o !== 2'b00 || btn_press_o !== 2'b00)
        $display("FAIL press_early edge=%0d level=%b press=%b want 00/00", i, btn_level_o, btn_press_o); else n_pass++;
    end
    tick();                       // edge k+5
    n_checks++; if (btn_level_o !== 2'b01) $display("FAIL press_level got %b want 01", btn_level_o); else n_pass++;
    n_checks++; if (btn_press_o !== 2'b01) $display("FAIL press_pulse got %b want 01", btn_press_o); else n_pass++;
    n_checks++; if (btn_release_o !== 2'b00) $display("FAIL press_no_release got %b want 00", btn_release_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (btn_press_o !== 2'b00 || btn_level_o !== 2'b01)
        $display("FAIL press_after edge=%0d press=%b level=%b want 00/01", i, btn_press_o, btn_level_o); else n_pass++;
    end
  endtask

  task automatic test_glitch();
    // Button 0 stays held; button 1 bounces: low 2, high 1, low 2, high.
    logic pat [0:12];
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 13; i++) begin
      btn_n_i = {pat[i], 1'b0};
      tick();
      n_checks++; if (btn_level_o[1] !== 1'b0 || btn_press_o !== 2'b00 || btn_release_o[1] !== 1'b0)
        $display("FAIL glitch step=%0d level=%b press=%b release=%b want level[1]=0 press=00", i, btn_level_o, btn_press_o, btn_release_o); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int both, p0, p1, r0, r1, bothr, stray;
    btn_n_i = 2'b11;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (btn_level_o !== 2'b00) $display("FAIL simul_idle got %b want 00", btn_level_o); else n_pass++;
    both = 0; p0 = 0; p1 = 0; stray = 0;
    btn_n_i = 2'b00;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (btn_press_o == 2'b11) both++;
      if (btn_press_o[0]) p0++;
      if (btn_press_o[1]) p1++;
      if (btn_release_o != 2'b00) stray++;
    end
    n_checks++; if (both !== 1) $display("FAIL simul_press_both got %0d want 1", both); else n_pass++;
    n_checks++; if (p0 !== 1 || p1 !== 1) $display("FAIL simul_press_count got %0d/%0d want 1/1", p0, p1); else n_pass++;
    n_checks++; if (btn_level_o !== 2'b11) $display("FAIL simul_level got %b want 11", btn_level_o); else n_pass++;
    bothr = 0; r0 = 0; r1 = 0;
    btn_n_i = 2'b11;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (btn_release_o == 2'b11) bothr++;
      if (btn_release_o[0]) r0++;
      if (btn_release_o[1]) r1++;
      if (btn_press_o != 2'b00) stray++;
    end
    n_checks++; if (bothr !== 1) $display("FAIL simul_release_both got %0d want 1", bothr); else n_pass++;
    n_checks++; if (r0 !== 1 || r1 !== 1) $display("FAIL simul_release_count got %0d/%0d want 1/1", r0, r1); else n_pass++;
    n_checks++; if (stray !== 0) $display("FAIL simul_stray_pulses got %0d want 0", stray); else n_pass++;
    n_checks++; if (btn_level_o !== 2'b00) $display("FAIL simul_level_off got %b want 00", btn_level_o); else n_pass++;
  endtask

  task automatic test_reset_midcount();
    btn_n_i = 2'b10;
    for (int i = 0; i < 4; i++) tick();   // counter for button 0 now at 2
    Reset = 1'b1;
    tick();
    n_checks++; if (btn_level_o !== 2'b00 || btn_press_o !== 2'b00 || btn_release_o !== 2'b00)
      $display("FAIL midrst_outputs level=%b press=%b release=%b want 00", btn_level_o, btn_press_o, btn_release_o); else n_pass++;
    Reset = 1'b0;
    for (int i = 0; i < D + 1; i++) begin  // edges 1..5 after release of Reset
      tick();
      n_checks++; if (btn_press_o !== 2'b00 || btn_level_o !== 2'b00)
        $display("FAIL midrst_early edge=%0d press=%b level=%b want 00/00", i + 1, btn_press_o, btn_level_o); else n_pass++;
    end
    tick();                                // edge 6
    n_checks++; if (btn_press_o !== 2'b01) $display("FAIL midrst_press got %b want 01", btn_press_o); else n_pass++;
    n_checks++; if (btn_level_o !== 2'b01) $display("FAIL midrst_level got %b want 01", btn_level_o); else n_pass++;
    tick();
    n_checks++; if (btn_press_o !== 2'b00) $display("FAIL midrst_single got %b want 00", btn_press_o); else n_pass++;
  endtask

  task automatic test_hold();
    int presses, releases;
    btn_n_i = 2'b11;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (btn_level_o !== 2'b00) $display("FAIL hold_idle got %b want 00", btn_level_o); else n_pass++;
    presses = 0;
    btn_n_i = 2'b10;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (btn_press_o[0]) presses++;
    end
    n_checks++; if (presses !== 1) $display("FAIL hold_press_count got %0d want 1", presses); else n_pass++;
    n_checks++; if (btn_level_o !== 2'b01) $display("FAIL hold_level got %b want 01", btn_level_o); else n_pass++;
    btn_n_i = 2'b11;
    for (int i = 0; i < D + 1; i++) begin
      tick();
      n_checks++; if (btn_release_o !== 2'b00 || btn_level_o !== 2'b01)
        $display("FAIL hold_release_early edge=%0d release=%b level=%b want 00/01", i, btn_release_o, btn_level_o); else n_pass++;
    end
    tick();                                // edge k+5 after release
    n_checks++; if (btn_release_o !== 2'b01) $display("FAIL hold_release got %b want 01", btn_release_o); else n_pass++;
    n_checks++; if (btn_level_o !== 2'b00) $display("FAIL hold_level_off got %b want 00", btn_level_o); else n_pass++;
    n_checks++; if (btn_press_o !== 2'b00) $display("FAIL hold_no_press got %b want 00", btn_press_o); else n_pass++;
    releases = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (btn_release_o != 2'b00 || btn_press_o != 2'b00) releases++;
    end
    n_checks++; if (releases !== 0) $display("FAIL hold_extra_pulses got %0d want 0", releases); else n_pass++;
  endtask

  initial begin
    Reset = 1'b1; btn_n_i = 2'b11; sw_i = '0;
    test_reset();
    test_press_latency();
    test_glitch();
    test_back_to_back();
    test_reset_midcount();
    test_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
